// File: rtl/regfile_mp_if.sv
// regfile_mp_if
// Bundles the read/write request bus and response signals of the myMIPS
// register file so the datapath and the bank share one connection.
//
// Parameters:
//   DWIDTH   data width in bits
//   AWIDTH   address width; the bank holds 2**AWIDTH entries
//
// Signals:
//   addr_rs, req_rs    read port A address and request
//   addr_rt, req_rt    read port B address and request
//   addr_rd, req_rd    write address and request
//   wdata              write data
//   rs, rt             registered read data for ports A and B
//   rs_valid, rt_valid one-cycle pulses marking a fresh rs/rt
//   busy               clear sweep in progress, requests ignored
//
// Modports:
//   master   the requester (decode/writeback side)
//   slave    the register file itself
interface regfile_mp_if #(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 8
);

   logic [AWIDTH-1:0] addr_rs;
   logic              req_rs;
   logic [AWIDTH-1:0] addr_rt;
   logic              req_rt;
   logic [AWIDTH-1:0] addr_rd;
   logic              req_rd;
   logic [DWIDTH-1:0] wdata;
   logic [DWIDTH-1:0] rs;
   logic [DWIDTH-1:0] rt;
   logic              rs_valid;
   logic              rt_valid;
   logic              busy;

   modport master (
      output addr_rs, req_rs, addr_rt, req_rt, addr_rd, req_rd, wdata,
      input  rs, rt, rs_valid, rt_valid, busy
   );

   modport slave (
      input  addr_rs, req_rs, addr_rt, req_rt, addr_rd, req_rd, wdata,
      output rs, rt, rs_valid, rt_valid, busy
   );

endinterface

// File: rtl/regfile_mp.sv
// regfile_mp
// Two-read/one-write register file for the myMIPS datapath. Everything
// happens on the rising edge of clk. The bank is cleared by sweeping zeros
// through it one entry per cycle, so the storage has a single write port
// and maps onto block RAM. Entry 0 can be hardwired to zero.
//
// Parameters:
//   DWIDTH    data width in bits
//   AWIDTH    address width; depth is 2**AWIDTH
//   ZERO_R0   nonzero: entry 0 reads as zero and ignores writes
//
// Ports:
//   clk       clock, rising edge
//   clear     synchronous active-high reset; starts a full clear sweep
//   bus       regfile_mp_if slave modport (requests in, read data out)
//
// Configuration:
//   REGFILE_MP_BYPASS_EN  when defined, a read that hits the entry being
//                         written in the same cycle returns the new wdata
//                         (write-first); otherwise it returns the old
//                         stored value (read-first).
module regfile_mp #(
   parameter int DWIDTH  = 16,
   parameter int AWIDTH  = 8,
   parameter int ZERO_R0 = 1
) (
   input logic         clk,
   input logic         clear,
   regfile_mp_if.slave bus
);

   typedef enum logic {
      SWEEP,
      READY
   } state_t;

   localparam int              Depth   = 2 ** AWIDTH;
   localparam logic [AWIDTH:0] LastIdx = (AWIDTH + 1)'(Depth - 1);

`ifdef REGFILE_MP_BYPASS_EN
   localparam bit BypassEn = 1'b1;
`else
   localparam bit BypassEn = 1'b0;
`endif

   logic [DWIDTH-1:0] mem [Depth];

   state_t            state_q, state_d;
   logic [AWIDTH:0]   sweepCnt_q, sweepCnt_d;
   logic [DWIDTH-1:0] rs_q, rs_d;
   logic [DWIDTH-1:0] rt_q, rt_d;
   logic              rsValid_q, rsValid_d;
   logic              rtValid_q, rtValid_d;
   logic              busy_q, busy_d;

   logic              memWe;
   logic [AWIDTH-1:0] memWaddr;
   logic [DWIDTH-1:0] memWdata;
   logic [DWIDTH-1:0] rsStored;
   logic [DWIDTH-1:0] rtStored;

   // The zero register overrides everything, then the optional forwarding
   // path, then the stored word.
   function automatic logic [DWIDTH-1:0] readMux(
      input logic [AWIDTH-1:0] addr,
      input logic [DWIDTH-1:0] stored,
      input logic              we,
      input logic [AWIDTH-1:0] wAddr,
      input logic [DWIDTH-1:0] wData
   );
      if ((ZERO_R0 != 0) && (addr == '0)) begin
         return '0;
      end
      if (BypassEn && we && (wAddr == addr)) begin
         return wData;
      end
      return stored;
   endfunction

   assign rsStored = mem[bus.addr_rs];
   assign rtStored = mem[bus.addr_rt];

   // Next-state logic. In SWEEP the single write port is borrowed by the
   // sweep and all requests are dropped; the counter carries one extra bit
   // so the final entry compares unambiguously. In READY the write port
   // serves req_rd (except the protected entry 0) and each read port loads
   // its output register only when requested.
   always_comb begin
      state_d    = state_q;
      sweepCnt_d = sweepCnt_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      rsValid_d  = 1'b0;
      rtValid_d  = 1'b0;
      memWe      = 1'b0;
      memWaddr   = bus.addr_rd;
      memWdata   = bus.wdata;

      case (state_q)
         SWEEP: begin
            memWe    = 1'b1;
            memWaddr = sweepCnt_q[AWIDTH-1:0];
            memWdata = '0;
            rs_d     = '0;
            rt_d     = '0;
            if (sweepCnt_q == LastIdx) begin
               state_d    = READY;
               sweepCnt_d = '0;
            end else begin
               sweepCnt_d = sweepCnt_q + 1'b1;
            end
         end
         READY: begin
            memWe = bus.req_rd && !((ZERO_R0 != 0) && (bus.addr_rd == '0));
            if (bus.req_rs) begin
               rs_d      = readMux(bus.addr_rs, rsStored, bus.req_rd,
                                   bus.addr_rd, bus.wdata);
               rsValid_d = 1'b1;
            end
            if (bus.req_rt) begin
               rt_d      = readMux(bus.addr_rt, rtStored, bus.req_rd,
                                   bus.addr_rd, bus.wdata);
               rtValid_d = 1'b1;
            end
         end
      endcase

      busy_d = (state_d == SWEEP);
   end

   // State and output registers; clear forces a fresh sweep from entry 0
   // and zeroes the read outputs regardless of the current state.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_q    <= SWEEP;
         sweepCnt_q <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rsValid_q  <= 1'b0;
         rtValid_q  <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         sweepCnt_q <= sweepCnt_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rsValid_q  <= rsValid_d;
         rtValid_q  <= rtValid_d;
         busy_q     <= busy_d;
      end
   end

   // Storage with one write port and no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (memWe && !clear) begin
         mem[memWaddr] <= memWdata;
      end
   end

   assign bus.rs       = rs_q;
   assign bus.rt       = rt_q;
   assign bus.rs_valid = rsValid_q;
   assign bus.rt_valid = rtValid_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Self-checking bench for regfile_mp with AWIDTH=4, DWIDTH=16, ZERO_R0=1.
// Stimulus is driven on the falling edge; every read request pushes its
// expected data (from a reference array kept by the bench) onto a per-port
// queue, and a monitor popping after each rising edge compares rs/rt.
// Scenario tasks additionally check specific values against constants.
// Honours REGFILE_MP_BYPASS_EN for the same-cycle read/write expectation.
module tb_regfile_mp;

   localparam int DW = 16;
   localparam int AW = 4;

`ifdef REGFILE_MP_BYPASS_EN
   localparam bit BypassTb = 1'b1;
`else
   localparam bit BypassTb = 1'b0;
`endif

   logic clk;
   logic clear;

   regfile_mp_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

   regfile_mp #(
      .DWIDTH (DW),
      .AWIDTH (AW),
      .ZERO_R0(1)
   ) dut (
      .clk  (clk),
      .clear(clear),
      .bus  (bus.slave)
   );

   int          tests = 0;
   int          fails = 0;
   logic [15:0] model [16];
   logic [15:0] rsQ [$];
   logic [15:0] rtQ [$];
   logic [15:0] lastRs = '0;
   logic [15:0] lastRt = '0;
   logic        tbBusy = 1'b1;
   logic        monEn = 1'b0;

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected read value from the reference array, zero register first.
   function automatic logic [15:0] modelRead(input logic [3:0] a,
                                             input logic rdEn,
                                             input logic [3:0] rdA,
                                             input logic [15:0] wd);
      if (a == 4'd0) return 16'h0000;
      if (BypassTb && rdEn && (rdA == a)) return wd;
      return model[a];
   endfunction

   // Scoreboard monitor: after each rising edge, a valid pulse must match
   // the oldest pending expectation; without a pulse nothing may be pending
   // and the output must hold its previous value.
   always begin
      @(posedge clk);
      #1;
      if (monEn) begin
         tests++;
         if (bus.rs_valid === 1'b1) begin
            if (rsQ.size() == 0) begin
               fails++;
               $display("[TB] FAIL rs_valid_spurious: rs=%h, no read pending", bus.rs);
            end else begin
               lastRs = rsQ.pop_front();
               if (bus.rs !== lastRs) begin
                  fails++;
                  $display("[TB] FAIL rs_data: got %h, expected %h", bus.rs, lastRs);
               end
            end
         end else if (rsQ.size() != 0) begin
            fails++;
            lastRs = rsQ.pop_front();
            $display("[TB] FAIL rs_valid_missing: valid=%b, expected 1 (data %h)",
                     bus.rs_valid, lastRs);
         end else if (bus.rs !== lastRs) begin
            fails++;
            $display("[TB] FAIL rs_hold: got %h, expected %h", bus.rs, lastRs);
         end

         tests++;
         if (bus.rt_valid === 1'b1) begin
            if (rtQ.size() == 0) begin
               fails++;
               $display("[TB] FAIL rt_valid_spurious: rt=%h, no read pending", bus.rt);
            end else begin
               lastRt = rtQ.pop_front();
               if (bus.rt !== lastRt) begin
                  fails++;
                  $display("[TB] FAIL rt_data: got %h, expected %h", bus.rt, lastRt);
               end
            end
         end else if (rtQ.size() != 0) begin
            fails++;
            lastRt = rtQ.pop_front();
            $display("[TB] FAIL rt_valid_missing: valid=%b, expected 1 (data %h)",
                     bus.rt_valid, lastRt);
         end else if (bus.rt !== lastRt) begin
            fails++;
            $display("[TB] FAIL rt_hold: got %h, expected %h", bus.rt, lastRt);
         end
      end
   end

   // One cycle of stimulus; pushes expectations and updates the reference
   // array unless the bank is sweeping.
   task automatic applyStimulus(input logic rsEn, input logic [3:0] rsA,
                                input logic rtEn, input logic [3:0] rtA,
                                input logic rdEn, input logic [3:0] rdA,
                                input logic [15:0] wd);
      @(negedge clk);
      bus.req_rs  = rsEn;
      bus.addr_rs = rsA;
      bus.req_rt  = rtEn;
      bus.addr_rt = rtA;
      bus.req_rd  = rdEn;
      bus.addr_rd = rdA;
      bus.wdata   = wd;
      if (!tbBusy) begin
         if (rsEn) rsQ.push_back(modelRead(rsA, rdEn, rdA, wd));
         if (rtEn) rtQ.push_back(modelRead(rtA, rdEn, rdA, wd));
         if (rdEn && (rdA != 4'd0)) model[rdA] = wd;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 16'h0);
   endtask

   // Drives clear for exactly one rising edge; returns at the falling edge
   // right after the edge that sampled it.
   task automatic pulseClear();
      @(negedge clk);
      clear       = 1'b1;
      bus.req_rs  = 1'b0;
      bus.req_rt  = 1'b0;
      bus.req_rd  = 1'b0;
      tbBusy      = 1'b1;
      lastRs      = '0;
      lastRt      = '0;
      monEn       = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   // Counts falling edges with busy high, bounded; then the reference
   // array reflects a fully cleared bank.
   task automatic waitReady(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) begin
         fails++;
         $display("[TB] FAIL busy_timeout: busy still %b after %0d cycles", bus.busy, n);
      end
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
      tbBusy = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      pulseClear();
      tests++;
      if (bus.busy !== 1'b1 || bus.rs !== 16'h0 || bus.rt !== 16'h0 ||
          bus.rs_valid !== 1'b0 || bus.rt_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_values: busy=%b rs=%h rt=%h rsv=%b rtv=%b, expected 1 0000 0000 0 0",
                  bus.busy, bus.rs, bus.rt, bus.rs_valid, bus.rt_valid);
      end
      waitReady(n);
      tests++;
      if (n != 16) begin
         fails++;
         $display("[TB] FAIL sweep_length: busy for %0d cycles, expected 16", n);
      end
      for (int i = 0; i < 16; i++) applyStimulus(1, 4'(i), 1, 4'(15 - i), 0, 0, 16'h0);
      idle(2);
   endtask

   task automatic test_basic_rw();
      applyStimulus(0, 0, 0, 0, 1, 4'd5, 16'hBEEF);
      applyStimulus(1, 4'd5, 0, 0, 0, 0, 16'h0);
      idle(1);
      tests++;
      if (bus.rs !== 16'hBEEF || bus.rs_valid !== 1'b1) begin
         fails++;
         $display("[TB] FAIL basic_read: rs=%h valid=%b, expected BEEF 1", bus.rs, bus.rs_valid);
      end
      idle(1);
      tests++;
      if (bus.rs !== 16'hBEEF || bus.rs_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL basic_hold: rs=%h valid=%b, expected BEEF 0", bus.rs, bus.rs_valid);
      end
      idle(2);
   endtask

   task automatic test_same_cycle();
      logic [15:0] exp;
      exp = BypassTb ? 16'h2222 : 16'h1111;
      applyStimulus(0, 0, 0, 0, 1, 4'd3, 16'h1111);
      applyStimulus(0, 0, 1, 4'd3, 1, 4'd3, 16'h2222);
      idle(1);
      tests++;
      if (bus.rt !== exp || bus.rt_valid !== 1'b1) begin
         fails++;
         $display("[TB] FAIL same_cycle_rw: rt=%h valid=%b, expected %h 1", bus.rt, bus.rt_valid, exp);
      end
      applyStimulus(0, 0, 1, 4'd3, 0, 0, 16'h0);
      idle(1);
      tests++;
      if (bus.rt !== 16'h2222) begin
         fails++;
         $display("[TB] FAIL after_write: rt=%h, expected 2222", bus.rt);
      end
   endtask

   task automatic test_zero_reg();
      applyStimulus(0, 0, 0, 0, 1, 4'd0, 16'hFFFF);
      applyStimulus(1, 4'd0, 1, 4'd0, 0, 0, 16'h0);
      idle(1);
      tests++;
      if (bus.rs !== 16'h0 || bus.rt !== 16'h0 || bus.rs_valid !== 1'b1 || bus.rt_valid !== 1'b1) begin
         fails++;
         $display("[TB] FAIL zero_reg: rs=%h rt=%h rsv=%b rtv=%b, expected 0000 0000 1 1",
                  bus.rs, bus.rt, bus.rs_valid, bus.rt_valid);
      end
   endtask

   task automatic test_mid_sweep();
      int n;
      applyStimulus(0, 0, 0, 0, 1, 4'd5, 16'h5555);
      pulseClear();
      applyStimulus(0, 0, 0, 0, 1, 4'd9, 16'hAAAA);
      applyStimulus(1, 4'd9, 1, 4'd5, 0, 0, 16'h0);
      idle(3);
      tests++;
      if (bus.busy !== 1'b1 || bus.rs_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL busy_during_sweep: busy=%b rsv=%b, expected 1 0", bus.busy, bus.rs_valid);
      end
      pulseClear();
      waitReady(n);
      tests++;
      if (n != 16) begin
         fails++;
         $display("[TB] FAIL restart_sweep_length: busy for %0d cycles after 2nd clear, expected 16", n);
      end
      applyStimulus(1, 4'd9, 1, 4'd5, 0, 0, 16'h0);
      idle(1);
      tests++;
      if (bus.rs !== 16'h0 || bus.rt !== 16'h0) begin
         fails++;
         $display("[TB] FAIL write_during_busy: rs=%h rt=%h, expected 0000 0000", bus.rs, bus.rt);
      end
   endtask

   task automatic test_dual_port();
      applyStimulus(0, 0, 0, 0, 1, 4'd2, 16'h0A0A);
      applyStimulus(0, 0, 0, 0, 1, 4'd4, 16'h0B0B);
      applyStimulus(1, 4'd2, 1, 4'd4, 0, 0, 16'h0);
      idle(1);
      tests++;
      if (bus.rs !== 16'h0A0A || bus.rt !== 16'h0B0B || bus.rs_valid !== 1'b1 || bus.rt_valid !== 1'b1) begin
         fails++;
         $display("[TB] FAIL dual_port: rs=%h rt=%h rsv=%b rtv=%b, expected 0A0A 0B0B 1 1",
                  bus.rs, bus.rt, bus.rs_valid, bus.rt_valid);
      end
      applyStimulus(1, 4'd4, 1, 4'd4, 0, 0, 16'h0);
      idle(1);
      tests++;
      if (bus.rs !== 16'h0B0B || bus.rt !== 16'h0B0B) begin
         fails++;
         $display("[TB] FAIL dual_same_addr: rs=%h rt=%h, expected 0B0B 0B0B", bus.rs, bus.rt);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 80; i++) begin
         applyStimulus(1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
                       1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
                       1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
                       16'($urandom));
      end
      idle(3);
   endtask

   // Checks that every queued expectation was consumed.
   task automatic checkOutput();
      tests++;
      if (rsQ.size() != 0 || rtQ.size() != 0) begin
         fails++;
         $display("[TB] FAIL drain: %0d rs and %0d rt reads outstanding, expected 0 0",
                  rsQ.size(), rtQ.size());
      end
   endtask

   // Scenario sequence.
   initial begin
      clear       = 1'b0;
      bus.req_rs  = 1'b0;
      bus.req_rt  = 1'b0;
      bus.req_rd  = 1'b0;
      bus.addr_rs = '0;
      bus.addr_rt = '0;
      bus.addr_rd = '0;
      bus.wdata   = '0;
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
      repeat (2) @(negedge clk);
      test_reset();
      test_basic_rw();
      test_same_cycle();
      test_zero_reg();
      test_mid_sweep();
      test_dual_port();
      test_back_to_back();
      checkOutput();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised two-read/one-write register file for the myMIPS datapath, and the successor of the current negedge-write register bank. All accesses are on the rising edge. Contents are cleared by a sequential sweep, one entry per cycle, so the bank maps onto block RAM. Entry 0 can be hardwired to zero, and optional write-to-read forwarding lets the decode stage see a same-cycle writeback.

## Interface
- `DWIDTH`, default 16: data width in bits.
- `AWIDTH`, default 8: address width; depth is `2**AWIDTH`.
- `ZERO_R0`, default 1: when 1, entry 0 reads as zero and ignores writes.
- `clk` input 1: clock; all logic on the rising edge.
- `clear` input 1: reset; synchronous, active-high.
- `addr_rs` input `AWIDTH`: read port A address.
- `req_rs` input 1: read port A request.
- `addr_rt` input `AWIDTH`: read port B address.
- `req_rt` input 1: read port B request.
- `addr_rd` input `AWIDTH`: write address.
- `req_rd` input 1: write request.
- `wdata` input `DWIDTH`: write data.
- `rs` output `DWIDTH`: read port A data, registered.
- `rt` output `DWIDTH`: read port B data, registered.
- `rs_valid` output 1: one-cycle pulse; `rs` was updated this cycle.
- `rt_valid` output 1: one-cycle pulse; `rt` was updated this cycle.
- `busy` output 1: clear sweep in progress; all requests are ignored.

## Operation
- **FSM states:** SWEEP and READY.
- **`clear` = 1, any state, takes priority:**
  - next state SWEEP, sweep counter 0;
  - `rs`, `rt` go to 0; `rs_valid`, `rt_valid` go to 0; `busy` goes to 1.
- **SWEEP:**
  - each cycle writes 0 to entry[counter], then counter+1;
  - after writing entry `2**AWIDTH-1`, next state READY and `busy` goes to 0;
  - `req_rs`, `req_rt`, `req_rd` are ignored;
  - `rs`/`rt` hold 0 and the valid flags stay 0.
- **`clear` asserted mid-sweep:** counter restarts at 0, giving a full sweep again.
- **Power-up:** the bench must assert `clear` before use. Contents before the first sweep are undefined.
- **READY, write:** `req_rd`=1 writes `wdata` to entry[`addr_rd`]. If `ZERO_R0`=1 and `addr_rd`=0, the write is dropped.
- **READY, read port A:** `req_rs`=1 loads `rs` and sets `rs_valid`=1 next cycle.
  - `req_rs`=0: `rs` holds its last value and `rs_valid`=0.
  - Port B (`rt`, `rt_valid`) behaves identically and independently.
- **Zero register:** with `ZERO_R0`=1, a read of address 0 returns 0 regardless of any write.
- **Same-cycle read/write, same address:** behaviour is set by the Configuration macro.
- **Dual read of the same address:** both ports return the same value.
- **Width:** data is stored and returned unmodified at `DWIDTH` bits. The sweep counter is `AWIDTH`+1 bits so the last entry is detected without wrap ambiguity.

## Timing
- **Read latency:** 1 cycle. Address and request are sampled at edge N; `rs`/`rt` and the valid flags appear after edge N.
- **Write:** takes effect at the sampling edge and is visible to any read sampled at a later edge.
- **Clear sweep:** `busy` goes high after the edge that samples `clear`=1. It stays high for exactly `2**AWIDTH` cycles after the last edge with `clear`=1, then drops.
- **Throughput:** one write and two reads per cycle, no stalls, in READY.
- **Reset values:** `rs`=0, `rt`=0, `rs_valid`=0, `rt_valid`=0, `busy`=1.

## Configuration
- **Macro:** `REGFILE_MP_BYPASS_EN`.
- **Defined (write-first):** if a read port and `req_rd` address the same entry in the same cycle, the read returns the new `wdata`.
  - The `ZERO_R0` rule still wins: address 0 returns 0.
- **Not defined (read-first):** the same-cycle read returns the old stored value; the new value is visible from the next read.
- The forwarding path is the mux on the read outputs. No other behaviour differs.

## Test plan
All scenarios use `AWIDTH`=4, `DWIDTH`=16.

- **Clear sweep:** `clear` high for 1 cycle -> `busy`=1 for exactly 16 cycles, then 0; every address then reads 0x0000.
- **Basic write/read:** write 0xBEEF to address 5, next cycle `req_rs` on address 5 -> `rs`=0xBEEF with a one-cycle `rs_valid`; with `req_rs`=0 afterwards, `rs` holds 0xBEEF.
- **Same-cycle read/write:** address 3 holds 0x1111; same cycle: write 0x2222 to 3 and `req_rt` on 3 -> `rt`=0x2222 with the macro defined, 0x1111 without.
- **Zero register:** `ZERO_R0`=1, write 0xFFFF to address 0, then read 0 on both ports -> `rs`=`rt`=0x0000, `rs_valid`=`rt_valid`=1.
- **Clear mid-sweep:** `clear` at cycle 0 and again at cycle 7 -> `busy` stays 1 until 16 cycles after the second clear; a write during `busy` (0xAAAA to address 9) is lost and address 9 reads 0x0000.
- **Dual port:** address 2 = 0x0A0A, address 4 = 0x0B0B; read both on `rs`/`rt` in the same cycle -> 0x0A0A / 0x0B0B, both valids set.
